pipe_ctrl_unit: RTL

- Pipelined successor to the combinational control decoder for the 5-stage MIPS core.
- Decodes the ID-stage instruction into the standard control bundle and carries it through EX, a parametrised number of MEM stages, and WB.
- Handles external stall, pending flush and load-use hazard detection, inserting a configurable number of bubbles.
- Sits between the instruction register and the datapath's stage muxes and register-file write port.

---
 rtl/pipe_ctrl_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Decodes the ID instruction and carries the control bundle through EX, MEM_STAGES MEM slots and WB (ID->WB = 2+MEM_STAGES edges).
// stall_in freezes every stage; load-use hazards insert LU_BUBBLES bubbles via stall_out; PIPE_CTRL_PERF_CNT_EN adds perf counters.
module pipe_ctrl_unit #(
  parameter int LU_BUBBLES = 1,
  parameter int MEM_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        illegal,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic [2:0]  ex_alu_src_b,
  output logic        ex_alu_reg_sel,
  output logic [1:0]  ex_jump_branch,
  output logic        ex_pc_plus8,
  output logic        mem_valid,
  output logic [3:0]  mem_write,
  output logic [2:0]  mem_ld_st_ctrl,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_dest
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_bubbles
`endif
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam logic [2:0] SRC_RT = 3'd0, SRC_RS = 3'd1, SRC_SEXT = 3'd2, SRC_ZEXT = 3'd3,
                         SRC_ZERO = 3'd4, SRC_SHAMT = 3'd5, SRC_LUI = 3'd6;
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  typedef struct packed {
    logic       vld;
    logic [3:0] alu_ctrl;
    logic [2:0] alu_src_b;
    logic       alu_reg_sel;
    logic [1:0] jump_branch;
    logic       pc_plus8;
    logic [3:0] mem_write;
    logic [2:0] ld_st_ctrl;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dest;
  } ctrl_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, dest;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  ctrl_t dec;
  logic  dec_illegal, uses_rs, uses_rt;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    uses_rs     = 1'b1;
    uses_rt     = 1'b0;
    dest        = rt;
    case (opcode)
      6'h00: begin
        dest          = rd;
        uses_rt       = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          6'h00: begin dec.alu_ctrl = ALU_SLL; dec.alu_src_b = SRC_SHAMT; dec.alu_reg_sel = 1'b1; uses_rs = 1'b0; end
          6'h02: begin dec.alu_ctrl = ALU_SRL; dec.alu_src_b = SRC_SHAMT; dec.alu_reg_sel = 1'b1; uses_rs = 1'b0; end
          6'h03: begin dec.alu_ctrl = ALU_SRA; dec.alu_src_b = SRC_SHAMT; dec.alu_reg_sel = 1'b1; uses_rs = 1'b0; end
          6'h04: begin dec.alu_ctrl = ALU_SLL; dec.alu_src_b = SRC_RS; dec.alu_reg_sel = 1'b1; end
          6'h06: begin dec.alu_ctrl = ALU_SRL; dec.alu_src_b = SRC_RS; dec.alu_reg_sel = 1'b1; end
          6'h07: begin dec.alu_ctrl = ALU_SRA; dec.alu_src_b = SRC_RS; dec.alu_reg_sel = 1'b1; end
          6'h08: begin dec.jump_branch = 2'b10; dec.reg_write = 1'b0; end
          6'h09: begin dec.jump_branch = 2'b10; dec.pc_plus8 = 1'b1; end
          6'h20, 6'h21: begin dec.alu_ctrl = ALU_ADD; end
          6'h22, 6'h23: begin dec.alu_ctrl = ALU_SUB; end
          6'h24: begin dec.alu_ctrl = ALU_AND; end
          6'h25: begin dec.alu_ctrl = ALU_OR; end
          6'h26: begin dec.alu_ctrl = ALU_XOR; end
          6'h27: begin dec.alu_ctrl = ALU_NOR; end
          6'h2a: begin dec.alu_ctrl = ALU_SLT; end
          6'h2b: begin dec.alu_ctrl = ALU_SLTU; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h02: begin dec.jump_branch = 2'b01; dec.alu_src_b = SRC_ZERO; uses_rs = 1'b0; end
      6'h03: begin
        dec.jump_branch = 2'b01; dec.alu_src_b = SRC_ZERO; dec.pc_plus8 = 1'b1;
        dec.reg_write = 1'b1; dest = 5'd31; uses_rs = 1'b0;
      end
      6'h04, 6'h05: begin dec.jump_branch = 2'b11; dec.alu_ctrl = ALU_SUB; dec.alu_src_b = SRC_RT; uses_rt = 1'b1; end
      6'h06, 6'h07: begin dec.jump_branch = 2'b11; dec.alu_ctrl = ALU_SUB; dec.alu_src_b = SRC_ZERO; end
      6'h08, 6'h09: begin dec.alu_ctrl = ALU_ADD;  dec.alu_src_b = SRC_SEXT; dec.reg_write = 1'b1; end
      6'h0a: begin dec.alu_ctrl = ALU_SLT;  dec.alu_src_b = SRC_SEXT; dec.reg_write = 1'b1; end
      6'h0b: begin dec.alu_ctrl = ALU_SLTU; dec.alu_src_b = SRC_SEXT; dec.reg_write = 1'b1; end
      6'h0c: begin dec.alu_ctrl = ALU_AND;  dec.alu_src_b = SRC_ZEXT; dec.reg_write = 1'b1; end
      6'h0d: begin dec.alu_ctrl = ALU_OR;   dec.alu_src_b = SRC_ZEXT; dec.reg_write = 1'b1; end
      6'h0e: begin dec.alu_ctrl = ALU_XOR;  dec.alu_src_b = SRC_ZEXT; dec.reg_write = 1'b1; end
      6'h0f: begin dec.alu_ctrl = ALU_LUI;  dec.alu_src_b = SRC_LUI;  dec.reg_write = 1'b1; uses_rs = 1'b0; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.alu_src_b  = SRC_SEXT;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        case (opcode)
          6'h20:   dec.ld_st_ctrl = 3'b000;
          6'h21:   dec.ld_st_ctrl = 3'b001;
          6'h23:   dec.ld_st_ctrl = 3'b010;
          6'h24:   dec.ld_st_ctrl = 3'b011;
          default: dec.ld_st_ctrl = 3'b100;
        endcase
      end
      6'h28: begin dec.alu_src_b = SRC_SEXT; dec.mem_write = 4'b0001; dec.ld_st_ctrl = 3'b101; uses_rt = 1'b1; end
      6'h29: begin dec.alu_src_b = SRC_SEXT; dec.mem_write = 4'b0011; dec.ld_st_ctrl = 3'b110; uses_rt = 1'b1; end
      6'h2b: begin dec.alu_src_b = SRC_SEXT; dec.mem_write = 4'b1111; dec.ld_st_ctrl = 3'b111; uses_rt = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
    dec.dest = dest;
    if (dest == 5'd0) dec.reg_write = 1'b0;
    dec.vld = 1'b1;
  end

  ctrl_t      ex_q, ex_d, wb_q, wb_d;
  ctrl_t      mem_q [MEM_STAGES];
  ctrl_t      mem_d [MEM_STAGES];
  logic [1:0] cnt_q, cnt_d;
  logic       flush_pending_q, flush_pending_d;
  logic       id_ok, hazard, flush_eff, cnt_busy;

  assign id_ok     = instr_valid & ~dec_illegal;
  assign flush_eff = flush | flush_pending_q;
  assign cnt_busy  = (cnt_q != 2'd0);
  assign hazard    = id_ok & ex_q.vld & ex_q.mem_to_reg & (ex_q.dest != 5'd0) &
                     ((uses_rs & (rs == ex_q.dest)) | (uses_rt & (rt == ex_q.dest)));
  // A flush that is about to take effect releases the hold: the ID instruction is dead anyway.
  assign stall_out = (hazard | cnt_busy) & ~(flush_eff & ~stall_in);
  assign illegal   = instr_valid & dec_illegal;

  always_comb begin
    ex_d            = ex_q;
    mem_d           = mem_q;
    wb_d            = wb_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    if (stall_in) begin
      flush_pending_d = flush_pending_q | flush;
    end else begin
      flush_pending_d = 1'b0;
      wb_d            = mem_q[MEM_STAGES-1];
      mem_d[0]        = ex_q;
      for (int i = 1; i < MEM_STAGES; i++) mem_d[i] = mem_q[i-1];
      ex_d = '0;
      if (flush_eff)     cnt_d = 2'd0;
      else if (cnt_busy) cnt_d = cnt_q - 2'd1;
      else if (hazard)   cnt_d = LU_INIT;
      else if (id_ok)    ex_d  = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q            <= '0;
      wb_q            <= '0;
      cnt_q           <= 2'd0;
      flush_pending_q <= 1'b0;
      for (int i = 0; i < MEM_STAGES; i++) mem_q[i] <= '0;
    end else begin
      ex_q            <= ex_d;
      wb_q            <= wb_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      for (int i = 0; i < MEM_STAGES; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign ex_valid       = ex_q.vld;
  assign ex_alu_ctrl    = ex_q.alu_ctrl;
  assign ex_alu_src_b   = ex_q.alu_src_b;
  assign ex_alu_reg_sel = ex_q.alu_reg_sel;
  assign ex_jump_branch = ex_q.jump_branch;
  assign ex_pc_plus8    = ex_q.pc_plus8;
  assign mem_valid      = mem_q[MEM_STAGES-1].vld;
  assign mem_write      = mem_q[MEM_STAGES-1].mem_write;
  assign mem_ld_st_ctrl = mem_q[MEM_STAGES-1].ld_st_ctrl;
  assign wb_valid       = wb_q.vld;
  assign wb_reg_write   = wb_q.reg_write & wb_q.vld;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_dest        = wb_q.dest;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d, perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {31'd0, ~stall_in & wb_d.vld};
    perf_bubbles_d = perf_bubbles_q + {31'd0, ~stall_in & ~flush_eff & (cnt_busy | hazard)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
